npu_wb_regif: RTL and testbench

NPU_WB_REGIF -- requirements
Module: npu_wb_regif

---
 rtl/npu_pkg.sv | 26 ++
 rtl/npu_sync_fifo.sv | 73 +++++++
 rtl/npu_wb_regif.sv | 133 +++++++++++++
 tb/tb_npu_wb_regif.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_pkg.sv
// Shared register map, bit positions and defaults for the NPU Wishbone register window.
package npu_pkg;

  localparam logic [31:0] NPU_BASE_ADDR = 32'h3000_0000;

  typedef enum logic [2:0] {
    OFF_CTRL   = 3'd0,
    OFF_STATUS = 3'd1,
    OFF_CMD    = 3'd2,
    OFF_RSP    = 3'd3,
    OFF_COUNT  = 3'd4
  } reg_off_e;

  localparam int CTRL_START  = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  localparam int ST_BUSY      = 0;
  localparam int ST_CMD_FULL  = 1;
  localparam int ST_CMD_EMPTY = 2;
  localparam int ST_RSP_EMPTY = 3;
  localparam int ST_DONE      = 4;
  localparam int ST_CMD_OVF   = 5;
  localparam int ST_RSP_UDF   = 6;

endpackage

// File: rtl/npu_sync_fifo.sv
// Single-clock FIFO with occupancy count; a flush wins over any same-cycle push or pop.
module npu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_FULL);
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  // A push into a full FIFO is only taken when a real pop frees the slot
  assign do_pop    = pop & ~empty & ~flush;
  assign do_push   = push & ~flush & (~full | do_pop);

  // Next-state pointers and count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else         wr_ptr_d = wr_ptr_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      else         rd_ptr_d = rd_ptr_q;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (!do_push && do_pop) count_d = count_q - CNT_ONE;
      else                         count_d = count_q;
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed since emptiness is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/npu_wb_regif.sv
// Wishbone classic slave exposing control/status and the command/response FIFOs of the NPU core.
module npu_wb_regif
  import npu_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = NPU_BASE_ADDR
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cmd_valid_o,
  output logic [31:0] cmd_data_o,
  input  logic        cmd_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic        rsp_ready_o,
  output logic        start_o,
  input  logic        busy_i,
  output logic        irq_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          ack_q, ack_d, start_q, start_d, irq_q, irq_d, irq_en_q, irq_en_d;
  logic          done_q, done_d, ovf_q, ovf_d, udf_q, udf_d, busy_q, busy_d;
  logic [31:0]   dat_q, dat_d, status_s, rdata_s, rsp_head_s;
  logic          req_s, hit_s, wr_s, rd_s, ctrl_wr_s, stat_wr_s, cmd_wr_s, rsp_rd_s, flush_s;
  logic          cmd_push_s, rsp_push_s, rsp_pop_s, done_set_s;
  logic          cmd_full_s, cmd_empty_s, rsp_full_s, rsp_empty_s;
  logic [CW-1:0] cmd_count_s, rsp_count_s;
  logic [2:0]    off_s;
  logic          unused_s;

  assign unused_s    = ^wbs_adr_i[1:0];
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign start_o     = start_q;
  assign irq_o       = irq_q;
  assign cmd_valid_o = ~cmd_empty_s;
  assign rsp_ready_o = ~rsp_full_s;

  npu_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(cmd_push_s), .pop(cmd_ready_i), .flush(flush_s),
    .push_data(wbs_dat_i), .head_data(cmd_data_o), .full(cmd_full_s), .empty(cmd_empty_s),
    .count(cmd_count_s)
  );

  npu_sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .push(rsp_push_s), .pop(rsp_pop_s), .flush(flush_s),
    .push_data(rsp_data_i), .head_data(rsp_head_s), .full(rsp_full_s), .empty(rsp_empty_s),
    .count(rsp_count_s)
  );

  // Request decode, register side effects and read-data mux
  always_comb begin
    req_s      = wbs_cyc_i & wbs_stb_i & ~ack_q;
    hit_s      = (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    off_s      = wbs_adr_i[4:2];
    wr_s       = req_s & hit_s & wbs_we_i;
    rd_s       = req_s & hit_s & ~wbs_we_i;
    ctrl_wr_s  = wr_s & (off_s == OFF_CTRL) & wbs_sel_i[0];
    stat_wr_s  = wr_s & (off_s == OFF_STATUS);
    cmd_wr_s   = wr_s & (off_s == OFF_CMD) & (wbs_sel_i == 4'hF);
    rsp_rd_s   = rd_s & (off_s == OFF_RSP);
    flush_s    = ctrl_wr_s & wbs_dat_i[CTRL_FLUSH];
    cmd_push_s = cmd_wr_s & ~cmd_full_s;
    rsp_push_s = rsp_valid_i & ~rsp_full_s;
    rsp_pop_s  = rsp_rd_s & ~rsp_empty_s;
    done_set_s = busy_q & ~busy_i;

    status_s               = 32'h0;
    status_s[ST_BUSY]      = busy_i;
    status_s[ST_CMD_FULL]  = cmd_full_s;
    status_s[ST_CMD_EMPTY] = cmd_empty_s;
    status_s[ST_RSP_EMPTY] = rsp_empty_s;
    status_s[ST_DONE]      = done_q;
    status_s[ST_CMD_OVF]   = ovf_q;
    status_s[ST_RSP_UDF]   = udf_q;

    rdata_s = 32'h0;
    case (off_s)
      OFF_CTRL:   rdata_s[CTRL_IRQ_EN] = irq_en_q;
      OFF_STATUS: rdata_s = status_s;
      OFF_RSP:    rdata_s = rsp_empty_s ? 32'h0 : rsp_head_s;
      OFF_COUNT:  rdata_s = {16'(rsp_count_s), 16'(cmd_count_s)};
      default:    rdata_s = 32'h0;
    endcase

    ack_d   = req_s;
    dat_d   = rd_s ? rdata_s : 32'h0;
    start_d = ctrl_wr_s & wbs_dat_i[CTRL_START];
    busy_d  = busy_i;
    if (ctrl_wr_s) irq_en_d = wbs_dat_i[CTRL_IRQ_EN];
    else           irq_en_d = irq_en_q;
    // A new DONE event outranks a same-cycle write-1-clear
    done_d = (done_q & ~(stat_wr_s & wbs_dat_i[ST_DONE])) | done_set_s;
    ovf_d  = (ovf_q & ~(stat_wr_s & wbs_dat_i[ST_CMD_OVF])) | (cmd_wr_s & cmd_full_s);
    udf_d  = (udf_q & ~(stat_wr_s & wbs_dat_i[ST_RSP_UDF])) | (rsp_rd_s & rsp_empty_s);
    irq_d  = done_d & irq_en_d;
  end

  // Bus response, control and sticky status registers
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q    <= 1'b0;
      dat_q    <= 32'h0;
      start_q  <= 1'b0;
      irq_q    <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_npu_wb_regif.sv
// Self-checking bench: directed register scenarios plus randomized traffic against a queue-based model.
module tb_npu_wb_regif;
  localparam int          DEPTH  = 8;
  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h00;
  localparam logic [31:0] A_STAT = BASE + 32'h04;
  localparam logic [31:0] A_CMD  = BASE + 32'h08;
  localparam logic [31:0] A_RSP  = BASE + 32'h0C;
  localparam logic [31:0] A_CNT  = BASE + 32'h10;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0, wdat = 32'h0;
  logic        ack, cmd_valid, rsp_ready, start, irq;
  logic [31:0] rdat, cmd_data;
  logic        cmd_ready = 1'b0, rsp_valid = 1'b0, busy = 1'b0;
  logic [31:0] rsp_data = 32'h0;

  int n_tests = 0, n_fail = 0, start_cnt = 0;

  logic [31:0] m_cmd[$], m_rsp[$];
  logic        m_ovf, m_udf, m_irq_en;

  npu_wb_regif #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .cmd_valid_o(cmd_valid), .cmd_data_o(cmd_data), .cmd_ready_i(cmd_ready),
    .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data), .rsp_ready_o(rsp_ready),
    .start_o(start), .busy_i(busy), .irq_o(irq)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (start) start_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] r);
    bit got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (ack) got = 1'b1;
    end
    r = rdat;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    chk("ack_seen", {31'h0, got}, 32'h1);
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    wb_xfer(1'b1, a, d, s, r);
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] r);
    wb_xfer(1'b0, a, 32'h0, 4'hF, r);
  endtask

  function automatic logic [31:0] m_status();
    return {25'h0, m_udf, m_ovf, 1'b0, m_rsp.size() == 0, m_cmd.size() == 0,
            m_cmd.size() == DEPTH, 1'b0};
  endfunction

  initial begin
    logic [31:0] r, d, exp;
    int snap, acks;
    repeat (3) tick();
    chk("rst_ack", {31'h0, ack}, 32'h0);
    chk("rst_dat", rdat, 32'h0);
    chk("rst_start", {31'h0, start}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    chk("rst_rsp_ready", {31'h0, rsp_ready}, 32'h1);
    rst = 1'b0;
    tick();
    wb_read(A_STAT, r);  chk("rst_status", r, 32'h0000_000C);

    // Three queued commands, then drained back-to-back
    wb_write(A_CMD, 32'h11, 4'hF);
    wb_write(A_CMD, 32'h22, 4'hF);
    wb_write(A_CMD, 32'h33, 4'hF);
    wb_read(A_CNT, r);   chk("count3", r, 32'h0000_0003);
    cmd_ready = 1'b1;
    chk("cmd_head0", cmd_data, 32'h11); tick();
    chk("cmd_head1", cmd_data, 32'h22); tick();
    chk("cmd_head2", cmd_data, 32'h33); tick();
    chk("cmd_drained", {31'h0, cmd_valid}, 32'h0);
    cmd_ready = 1'b0;

    // Overflow on the ninth write
    for (int i = 0; i < 9; i++) wb_write(A_CMD, 32'h100 + i, 4'hF);
    wb_read(A_CNT, r);   chk("count_full", r & 32'hFFFF, 32'h8);
    wb_read(A_STAT, r);  chk("ovf_set", (r >> 5) & 32'h1, 32'h1);
    wb_write(A_STAT, 32'h20, 4'hF);
    wb_read(A_STAT, r);  chk("ovf_clr", (r >> 5) & 32'h1, 32'h0);
    cmd_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("ovf_keep_data", cmd_data, 32'h100 + i);
      tick();
    end
    cmd_ready = 1'b0;

    // Response pop and underflow
    rsp_valid = 1'b1; rsp_data = 32'hA5A5_0001; tick(); rsp_valid = 1'b0;
    wb_read(A_RSP, r);   chk("rsp_data", r, 32'hA5A5_0001);
    wb_read(A_RSP, r);   chk("rsp_empty_read", r, 32'h0);
    wb_read(A_STAT, r);  chk("udf_set", (r >> 6) & 32'h1, 32'h1);
    wb_write(A_STAT, 32'h40, 4'hF);

    // Start pulse, DONE and interrupt
    snap = start_cnt;
    wb_write(A_CTRL, 32'h3, 4'hF);
    repeat (3) tick();
    chk("start_width", start_cnt - snap, 32'h1);
    wb_read(A_CTRL, r);  chk("ctrl_read", r, 32'h2);
    busy = 1'b1; repeat (5) tick(); busy = 1'b0; repeat (3) tick();
    wb_read(A_STAT, r);  chk("done_set", (r >> 4) & 32'h1, 32'h1);
    chk("irq_on", {31'h0, irq}, 32'h1);
    wb_write(A_STAT, 32'h10, 4'hF); tick();
    chk("irq_off", {31'h0, irq}, 32'h0);
    // DONE event and its clear land on the same decode cycle
    busy = 1'b1; repeat (3) tick(); busy = 1'b0;
    wb_write(A_STAT, 32'h10, 4'hF);
    wb_read(A_STAT, r);  chk("done_set_wins", (r >> 4) & 32'h1, 32'h1);
    chk("irq_after_race", {31'h0, irq}, 32'h1);
    wb_write(A_STAT, 32'h10, 4'hF);
    wb_read(A_STAT, r);  chk("done_clr", (r >> 4) & 32'h1, 32'h0);

    // Held cyc/stb gives one-cycle acks on alternate cycles
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_STAT; acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ack_alt", {31'h0, ack}, (i % 2 == 0) ? 32'h1 : 32'h0);
      acks += int'(ack);
    end
    cyc = 1'b0; stb = 1'b0;
    chk("ack_total", acks, 32'h3);
    tick();

    // Randomized traffic from a known state
    wb_write(A_CTRL, 32'h4, 4'hF);
    m_cmd.delete(); m_rsp.delete(); m_ovf = 1'b0; m_udf = 1'b0; m_irq_en = 1'b0;
    for (int it = 0; it < 400; it++) begin
      d = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          sel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
          wb_write(A_CMD, d, sel);
          if (sel == 4'hF) begin
            if (m_cmd.size() < DEPTH) m_cmd.push_back(d);
            else m_ovf = 1'b1;
          end
        end
        3: begin
          wb_read(A_RSP, r);
          if (m_rsp.size() > 0) exp = m_rsp.pop_front();
          else begin exp = 32'h0; m_udf = 1'b1; end
          chk("rnd_rsp", r, exp);
        end
        4: begin
          wb_read(A_CNT, r);
          chk("rnd_count", r, {16'(m_rsp.size()), 16'(m_cmd.size())});
        end
        5: begin
          wb_read(A_STAT, r);
          chk("rnd_status", r, m_status());
        end
        6: begin
          rsp_valid = 1'b1; rsp_data = d;
          chk("rnd_rsp_ready", {31'h0, rsp_ready}, (m_rsp.size() < DEPTH) ? 32'h1 : 32'h0);
          tick();
          rsp_valid = 1'b0;
          if (m_rsp.size() < DEPTH) m_rsp.push_back(d);
        end
        7: begin
          chk("rnd_cmd_valid", {31'h0, cmd_valid}, (m_cmd.size() > 0) ? 32'h1 : 32'h0);
          if (m_cmd.size() > 0) begin
            chk("rnd_cmd_data", cmd_data, m_cmd[0]);
            cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
            void'(m_cmd.pop_front());
          end
        end
        8: begin
          if ($urandom_range(0, 1) == 1) begin
            wb_write(A_STAT, d & 32'h70, 4'hF);
            if (d[5]) m_ovf = 1'b0;
            if (d[6]) m_udf = 1'b0;
          end else begin
            d = {29'h0, ($urandom_range(0, 3) == 0), d[1], 1'b0};
            sel = 4'($urandom_range(0, 15));
            wb_write(A_CTRL, d, sel);
            if (sel[0]) begin
              m_irq_en = d[1];
              if (d[2]) begin m_cmd.delete(); m_rsp.delete(); end
            end
            wb_read(A_CTRL, r);
            chk("rnd_ctrl", r, {30'h0, m_irq_en, 1'b0});
          end
        end
        default: begin
          wb_write(BASE ^ (32'h1 << $urandom_range(5, 31)) | 32'h8, d, 4'hF);
          wb_read(BASE | (32'($urandom_range(5, 7)) << 2), r);
          chk("rnd_unmapped", r, 32'h0);
          wb_read(A_CMD, r);
          chk("rnd_cmd_wo", r, 32'h0);
        end
      endcase
      chk("rnd_irq", {31'h0, irq}, 32'h0);
    end

    // Reset with commands queued and a request in flight
    wb_write(A_CTRL, 32'h6, 4'hF);
    for (int i = 0; i < 4; i++) wb_write(A_CMD, 32'hC0 + i, 4'hF);
    chk("pre_rst_valid", {31'h0, cmd_valid}, 32'h1);
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_CNT; rst = 1'b1;
    tick();
    chk("mid_rst_ack", {31'h0, ack}, 32'h0);
    chk("mid_rst_dat", rdat, 32'h0);
    chk("mid_rst_start", {31'h0, start}, 32'h0);
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_cmd_valid", {31'h0, cmd_valid}, 32'h0);
    chk("mid_rst_rsp_ready", {31'h0, rsp_ready}, 32'h1);
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    tick();
    wb_read(A_CNT, r);   chk("post_rst_count", r, 32'h0);
    wb_read(A_CTRL, r);  chk("post_rst_ctrl", r, 32'h0);
    wb_read(A_STAT, r);  chk("post_rst_status", r, 32'h0000_000C);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
